// File: rtl/kypd_pkg.sv
// Shared keypad definitions: key-code to (row,col) map, emulator FSM states
// and the bounce LFSR tap mask.
package kypd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_P,
    ST_HOLD,
    ST_BOUNCE_R,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // x^8+x^6+x^5+x^4+1, shift-left form: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t pos;
    case (key)
      4'h1:    pos = '{row: 2'd0, col: 2'd0};
      4'h2:    pos = '{row: 2'd0, col: 2'd1};
      4'h3:    pos = '{row: 2'd0, col: 2'd2};
      4'hA:    pos = '{row: 2'd0, col: 2'd3};
      4'h4:    pos = '{row: 2'd1, col: 2'd0};
      4'h5:    pos = '{row: 2'd1, col: 2'd1};
      4'h6:    pos = '{row: 2'd1, col: 2'd2};
      4'hB:    pos = '{row: 2'd1, col: 2'd3};
      4'h7:    pos = '{row: 2'd2, col: 2'd0};
      4'h8:    pos = '{row: 2'd2, col: 2'd1};
      4'h9:    pos = '{row: 2'd2, col: 2'd2};
      4'hC:    pos = '{row: 2'd2, col: 2'd3};
      4'h0:    pos = '{row: 2'd3, col: 2'd0};
      4'hF:    pos = '{row: 2'd3, col: 2'd1};
      4'hE:    pos = '{row: 2'd3, col: 2'd2};
      default: pos = '{row: 2'd3, col: 2'd3};
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/keypad_emulator_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when enabled; supplies the
// pseudo-random contact chatter for the keypad emulator.
module lfsr8
  import kypd_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);
  assign q    = r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= SEED;
    end else if (en) begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad stand-in: plays out commanded key presses with contact bounce
// and answers the scanner's active-low column strobes with row levels.
module keypad_emulator
  import kypd_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_hold;
  logic [3:0]  r_key;
  logic        r_done;
  logic [3:0]  r_row;

  logic        w_accept;
  logic        w_lfsr_en;
  logic        w_contact;
  logic [7:0]  w_lfsr;
  logic [15:0] w_hold_load;
  logic [3:0]  w_row_next;
  key_pos_t    w_pos;

  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  assign w_lfsr_en   = (r_state == ST_BOUNCE_P) || (r_state == ST_BOUNCE_R);
  assign w_hold_load = (r_hold == 16'd0) ? 16'd0 : r_hold - 16'd1;
  assign w_pos       = key_to_pos(r_key);

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign row       = r_row;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_lfsr_en),
    .q   (w_lfsr)
  );

  always_comb begin
    w_contact = 1'b0;
    case (r_state)
      ST_BOUNCE_P, ST_BOUNCE_R: w_contact = w_lfsr[0];
      ST_HOLD:                  w_contact = 1'b1;
      default:                  w_contact = 1'b0;
    endcase
  end

  // Only the pressed key's row can be pulled low, and only while its column is strobed
  always_comb begin
    w_row_next = 4'b1111;
    if (w_contact && !col[w_pos.col]) begin
      w_row_next[w_pos.row] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= 4'b1111;
    end else begin
      r_row <= w_row_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= 16'd0;
      r_hold  <= 16'd0;
      r_key   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_key   <= cmd_key;
            r_hold  <= cmd_hold;
            r_count <= BOUNCE_LOAD;
            r_state <= ST_BOUNCE_P;
          end
        end
        ST_BOUNCE_P: begin
          if (r_count == 16'd0) begin
            r_count <= w_hold_load;
            r_state <= ST_HOLD;
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        ST_HOLD: begin
          if (r_count == 16'd0) begin
            r_count <= BOUNCE_LOAD;
            r_state <= ST_BOUNCE_R;
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        ST_BOUNCE_R: begin
          if (r_count == 16'd0) begin
            r_count <= GAP_LOAD;
            r_state <= ST_GAP;
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        ST_GAP: begin
          if (r_count == 16'd0) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: a timeline model of each press and a
// reference LFSR predict row/done/ready/busy one cycle ahead of the DUT.
module tb_keypad_emulator;

  localparam int BOUNCE = 16;
  localparam int GAP    = 8;

  typedef struct packed {
    logic [3:0] row;
    logic       done;
    logic       ready;
    logic       busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col = 4'b1111;
  logic [3:0]  row;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [3:0]  cmdKey = 4'd0;
  logic [15:0] cmdHold = 16'd0;
  logic        busy;
  logic        done;

  int          nCompared = 0;
  int          nMismatched = 0;
  logic [7:0]  mLfsr = 8'hA5;
  exp_t        sbQ[$];
  logic [3:0]  rowLog[0:127];
  logic [3:0]  run1Log[0:15];
  int          keyLayout[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                                   '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  keypad_emulator #(
    .BOUNCE_CYCLES (BOUNCE),
    .GAP_CYCLES    (GAP),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_key   (cmdKey),
    .cmd_hold  (cmdHold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic find_key(input logic [3:0] key, output int kr, output int kc);
    kr = 0;
    kc = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyLayout[r][c] == int'(key)) begin
          kr = r;
          kc = c;
        end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cmdValid = 1'b0;
    mLfsr = 8'hA5;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic accept_cmd(input logic [3:0] key, input logic [15:0] hold);
    int waited;
    waited = 0;
    while (!cmdReady && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    nCompared++;
    if (!cmdReady) begin
      nMismatched++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmdReady, waited);
    end
    cmdValid = 1'b1;
    cmdKey   = key;
    cmdHold  = hold;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    nCompared++;
    if (busy !== 1'b1 || cmdReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL accept: busy=%b ready=%b, required busy=1 ready=0", busy, cmdReady);
    end
  endtask

  // Called right after the accept edge; returns #1 after the done edge.
  task automatic play_press(input logic [3:0] key, input int holdCycles, input bit rotate,
                            input logic [3:0] fixedCol, input bit logRows);
    int   hEff, len, kr, kc;
    bit   inBounce;
    logic contact;
    exp_t e;
    hEff = (holdCycles == 0) ? 1 : holdCycles;
    len  = 2 * BOUNCE + hEff + GAP;
    find_key(key, kr, kc);
    for (int k = 0; k < len; k++) begin
      col = rotate ? ~(4'b0001 << (k % 4)) : fixedCol;
      inBounce = (k < BOUNCE) || (k >= BOUNCE + hEff && k < 2 * BOUNCE + hEff);
      if (inBounce) begin
        contact = mLfsr[0];
        mLfsr = lfsr_step(mLfsr);
      end else begin
        contact = (k >= BOUNCE && k < BOUNCE + hEff);
      end
      e.row = 4'b1111;
      if (contact && col[kc] == 1'b0) e.row[kr] = 1'b0;
      e.done  = (k == len - 1);
      e.ready = (k == len - 1);
      e.busy  = (k != len - 1);
      sbQ.push_back(e);
      @(posedge clk); #1;
      e = sbQ.pop_front();
      if (logRows) rowLog[k] = row;
      nCompared++;
      if (row !== e.row) begin
        nMismatched++;
        $display("[TB] FAIL row key=%h cycle=%0d: got %b expected %b", key, k + 1, row, e.row);
      end
      nCompared++;
      if (done !== e.done) begin
        nMismatched++;
        $display("[TB] FAIL done key=%h cycle=%0d: got %b expected %b", key, k + 1, done, e.done);
      end
      nCompared++;
      if (cmdReady !== e.ready) begin
        nMismatched++;
        $display("[TB] FAIL ready key=%h cycle=%0d: got %b expected %b", key, k + 1, cmdReady, e.ready);
      end
      nCompared++;
      if (busy !== e.busy) begin
        nMismatched++;
        $display("[TB] FAIL busy key=%h cycle=%0d: got %b expected %b", key, k + 1, busy, e.busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mLfsr = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) rst = 1'b1;
      col = 4'($urandom);
      @(posedge clk); #1;
      nCompared++;
      if (row !== 4'b1111 || cmdReady !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL reset_idle i=%0d: row=%b ready=%b busy=%b done=%b, required 1111/1/0/0",
                 i, row, cmdReady, busy, done);
      end
    end
  endtask

  task automatic test_press_scan();
    accept_cmd(4'h5, 16'd40);
    play_press(4'h5, 40, 1'b1, 4'b1111, 1'b0);
  endtask

  task automatic test_zero_hold();
    col = 4'b0111;
    accept_cmd(4'hD, 16'd0);
    play_press(4'hD, 0, 1'b0, 4'b0111, 1'b0);
  endtask

  task automatic test_back_to_back();
    accept_cmd(4'h9, 16'd12);
    cmdValid = 1'b1;
    cmdKey   = 4'h3;
    cmdHold  = 16'd5;
    play_press(4'h9, 12, 1'b1, 4'b1111, 1'b0);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    nCompared++;
    if (busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL chained_accept: busy=%b, required 1", busy);
    end
    play_press(4'h3, 5, 1'b1, 4'b1111, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      nCompared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL single_accept: busy=%b done=%b, required 0/0", busy, done);
      end
    end
  endtask

  task automatic test_bounce_determinism();
    for (int run = 0; run < 2; run++) begin
      do_reset();
      col = 4'b1110;
      accept_cmd(4'h1, 16'd10);
      play_press(4'h1, 10, 1'b0, 4'b1110, 1'b1);
      if (run == 0) begin
        for (int k = 0; k < 16; k++) run1Log[k] = rowLog[k];
      end else begin
        for (int k = 0; k < 16; k++) begin
          nCompared++;
          if (rowLog[k] !== run1Log[k]) begin
            nMismatched++;
            $display("[TB] FAIL repeat_chatter cycle=%0d: got %b first run %b", k + 1, rowLog[k], run1Log[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    col = 4'b0111;
    accept_cmd(4'hA, 16'd30);
    repeat (21) @(posedge clk);
    #1;
    nCompared++;
    if (row !== 4'b1110) begin
      nMismatched++;
      $display("[TB] FAIL hold_row_A: got %b expected 1110", row);
    end
    #3 rst = 1'b0;
    mLfsr = 8'hA5;
    #1;
    nCompared++;
    if (row !== 4'b1111 || busy !== 1'b0 || cmdReady !== 1'b1 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: row=%b busy=%b ready=%b done=%b, required 1111/0/1/0",
               row, busy, cmdReady, done);
    end
    @(posedge clk); #1;
    nCompared++;
    if (row !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_held: row=%b busy=%b done=%b, required 1111/0/0", row, busy, done);
    end
    rst = 1'b1;
    accept_cmd(4'h7, 16'd4);
    play_press(4'h7, 4, 1'b1, 4'b1111, 1'b0);
  endtask

  initial begin
    $display("[TB] keypad_emulator bench start");
    test_reset();
    test_press_scan();
    test_zero_hold();
    test_back_to_back();
    test_bounce_determinism();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
